int_ctrl: RTL
=============

Name: int_ctrl

Overview:
- Trap sequencer and CSR write-port arbiter for the core.
- Detects ecall/ebreak and external interrupts (gated by mstatus.MIE) and holds the pipeline.
- Writes mepc, mstatus and mcause through the shared CSR write port, then redirects fetch to mtvec.
- On mret, restores mstatus and redirects fetch to mepc.
- Sits between ex, csr_reg and ctrl; it replaces the ad-hoc per-cycle CSR writes.

Parameters:
INT_NUM, 8, number of external interrupt lines (cause index width = clog2(INT_NUM)).
ADDR_W, 32, instruction-address and CSR data width.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
int_flag_i  in  INT_NUM  level interrupt requests; bit 0 is highest priority
inst_i  in  32  instruction currently in ex
inst_addr_i  in  ADDR_W  address of inst_i
jump_flag_i  in  1  ex is redirecting this cycle
jump_addr_i  in  ADDR_W  ex redirect target
csr_mstatus_i  in  32  current mstatus
csr_mtvec_i  in  32  current mtvec
csr_mepc_i  in  32  current mepc
ex_we_i  in  1  ex CSR write request
ex_waddr_i  in  32  ex CSR write address
ex_wdata_i  in  32  ex CSR write data
csr_we_o  out  1  CSR write enable to csr_reg
csr_waddr_o  out  32  CSR write address
csr_wdata_o  out  32  CSR write data
hold_flag_o  out  1  pipeline hold request to ctrl
int_assert_o  out  1  one-cycle redirect strobe
int_addr_o  out  ADDR_W  redirect target, valid with int_assert_o

Behaviour:
- Reset (rst low, async):
  - State goes to IDLE.
  - All outputs are 0; latched cause and epc are 0.
  - No partial CSR write completes, including on reset mid-sequence.
- Trap request in IDLE, evaluated in cycle N, highest priority first:
  - MRET: inst_i == INST_MRET.
  - SYNC: inst_i == INST_ECALL (cause 11) or INST_EBREAK (cause 3); epc = inst_addr_i.
  - ASYNC: int_flag_i != 0 and csr_mstatus_i[3] == 1.
    - Cause = 32'h8000_0000 | (index of lowest set bit).
    - epc = jump_addr_i if jump_flag_i, else inst_addr_i.
- hold_flag_o is combinational: (state != IDLE) OR (a trap request is seen in IDLE).
- Trap entry states:
  - IDLE -> W_MEPC at N+1: write mepc = epc.
  - W_MEPC -> W_MSTATUS at N+2: write csr_mstatus_i with bit7 = old bit3 and bit3 = 0; other bits unchanged.
  - W_MSTATUS -> W_MCAUSE at N+3: write mcause = latched cause.
  - W_MCAUSE -> ASSERT at N+4: int_assert_o = 1, int_addr_o = csr_mtvec_i.
  - ASSERT -> IDLE.
- MRET states:
  - IDLE -> R_MSTATUS at N+1: write mstatus with bit3 = old bit7, bit7 = 1.
  - R_MSTATUS -> R_ASSERT at N+2: int_assert_o = 1, int_addr_o = csr_mepc_i.
  - R_ASSERT -> IDLE.
- CSR port arbitration:
  - In W_*/R_MSTATUS the FSM owns the port; ex_we_i is ignored there (ex is held, so it must be 0).
  - Otherwise, including IDLE in cycle N, csr_* passes ex_* through combinationally.
- Hold and redirect timing:
  - hold_flag_o deasserts in the cycle after ASSERT/R_ASSERT.
  - int_assert_o is high for exactly one cycle per trap or mret.
- Simultaneous and interleaved events:
  - MRET plus a pending interrupt: MRET wins; the interrupt is re-evaluated in IDLE after R_ASSERT. It is taken if MIE is now 1, giving back-to-back sequences.
  - Interrupt lines changing mid-sequence are ignored. Cause is latched in cycle N only; lines are level-sensitive and re-sampled in IDLE.
  - Multiple lines set: the lowest index wins; cause bit 31 is set.
- Arithmetic: no counters; the cause index is zero-extended to 31 bits.

Decomposition:
- defines.v owns:
  - INST_ECALL 32'h00000073, INST_EBREAK 32'h00100073, INST_MRET 32'h30200073.
  - CSR_MSTATUS 12'h300, CSR_MTVEC 12'h305, CSR_MEPC 12'h341, CSR_MCAUSE 12'h342.
  - INT_ASSERT/INT_DEASSERT.
- State encoding is localparam inside the module (7 states).
- One sub-module: int_prio_enc, parameterised by INT_NUM. It produces a valid flag and the lowest-set-bit index.

Test Plan:
- Reset: rst low mid-W_MSTATUS -> all outputs 0 immediately. After release, no mcause write is seen and state is IDLE.
- ECALL: inst_i=32'h73, inst_addr_i=0x100, mtvec=0x200.
  - Writes in order: mepc=0x100 (N+1), mstatus MIE->MPIE (N+2), mcause=11 (N+3).
  - int_assert_o=1 with int_addr_o=0x200 at N+4; hold high N..N+4.
- Interrupt with jump in flight: int_flag_i=8'b0000_0110, MIE=1, jump_flag_i=1, jump_addr_i=0x340.
  - mepc=0x340, mcause=0x8000_0001.
  - With MIE=0, no hold and no writes.
- MRET: inst_i=MRET, mstatus=0x80, mepc=0x340 -> mstatus write 0x88 at N+1; int_assert_o with int_addr_o=0x340 at N+2.
- MRET with pending int_flag_i=1: mret completes first, then a full trap sequence starts the next IDLE cycle (mcause=0x8000_0000).
- Arbitration: ex_we_i=1, waddr=0x305 in IDLE with no trap -> passes through same cycle. During W_MEPC, ex_we_i=1 is ignored and csr_waddr_o=0x341.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// Shared constants and helpers for the trap sequencer: instruction encodings,
// CSR addresses and the mstatus rewrite rules used on trap entry and mret.
package int_ctrl_pkg;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic INT_ASSERT   = 1'b1;
    localparam logic INT_DEASSERT = 1'b0;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;

    // Trap entry: MPIE takes the old MIE, MIE is cleared.
    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[7] = m[3];
        r[3] = 1'b0;
        return r;
    endfunction

    // mret: MIE takes the old MPIE, MPIE is set.
    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
        logic [31:0] r;
        r    = m;
        r[3] = m[7];
        r[7] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder over the external interrupt lines.
module int_prio_enc #(
    parameter int INT_NUM = 8,
    parameter int IDX_W   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1
) (
    input  logic [INT_NUM-1:0] req_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the last hit, the lowest set bit, sticks.
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Trap sequencer: takes ecall/ebreak/interrupts and mret, drives the shared CSR
// write port through the mepc/mstatus/mcause updates, then strobes a redirect.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int INT_NUM = 8,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INT_NUM-1:0] int_flag_i,
    input  logic [31:0]        inst_i,
    input  logic [ADDR_W-1:0]  inst_addr_i,
    input  logic               jump_flag_i,
    input  logic [ADDR_W-1:0]  jump_addr_i,
    input  logic [31:0]        csr_mstatus_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic               ex_we_i,
    input  logic [31:0]        ex_waddr_i,
    input  logic [31:0]        ex_wdata_i,
    output logic               csr_we_o,
    output logic [31:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               hold_flag_o,
    output logic               int_assert_o,
    output logic [ADDR_W-1:0]  int_addr_o
);

    localparam int IDX_W = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MSTATUS = 3'd2,
        S_W_MCAUSE  = 3'd3,
        S_ASSERT    = 3'd4,
        S_R_MSTATUS = 3'd5,
        S_R_ASSERT  = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        cause_q, cause_d;
    logic [ADDR_W-1:0]  epc_q, epc_d;

    logic               irq_valid;
    logic [IDX_W-1:0]   irq_idx;
    logic               is_mret, is_ecall, is_ebreak, async_req, trap_req;

    int_prio_enc #(
        .INT_NUM (INT_NUM),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .req_i   (int_flag_i),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    always_comb begin
        is_mret   = (inst_i == INST_MRET);
        is_ecall  = (inst_i == INST_ECALL);
        is_ebreak = (inst_i == INST_EBREAK);
        async_req = irq_valid && csr_mstatus_i[3];
        trap_req  = is_mret || is_ecall || is_ebreak || async_req;
    end

    // Next state; cause and epc are captured only on the IDLE exit cycle.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        case (state_q)
            S_IDLE: begin
                if (is_mret) begin
                    state_d = S_R_MSTATUS;
                end else if (is_ecall || is_ebreak) begin
                    state_d = S_W_MEPC;
                    cause_d = is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
                    epc_d   = inst_addr_i;
                end else if (async_req) begin
                    state_d = S_W_MEPC;
                    cause_d = 32'h8000_0000 | 32'(irq_idx);
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                end
            end
            S_W_MEPC:    state_d = S_W_MSTATUS;
            S_W_MSTATUS: state_d = S_W_MCAUSE;
            S_W_MCAUSE:  state_d = S_ASSERT;
            S_ASSERT:    state_d = S_IDLE;
            S_R_MSTATUS: state_d = S_R_ASSERT;
            S_R_ASSERT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // The FSM owns the CSR port while writing; ex is held then, so its request is dropped.
    always_comb begin
        csr_we_o     = ex_we_i;
        csr_waddr_o  = ex_waddr_i;
        csr_wdata_o  = ex_wdata_i;
        hold_flag_o  = (state_q != S_IDLE) || trap_req;
        int_assert_o = INT_DEASSERT;
        int_addr_o   = '0;
        case (state_q)
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'h0, CSR_MEPC};
                csr_wdata_o = 32'(epc_q);
            end
            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'h0, CSR_MSTATUS};
                csr_wdata_o = mstatus_on_trap(csr_mstatus_i);
            end
            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'h0, CSR_MCAUSE};
                csr_wdata_o = cause_q;
            end
            S_ASSERT: begin
                int_assert_o = INT_ASSERT;
                int_addr_o   = ADDR_W'(csr_mtvec_i);
            end
            S_R_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = {20'h0, CSR_MSTATUS};
                csr_wdata_o = mstatus_on_mret(csr_mstatus_i);
            end
            S_R_ASSERT: begin
                int_assert_o = INT_ASSERT;
                int_addr_o   = ADDR_W'(csr_mepc_i);
            end
            default: ;
        endcase
        // While reset is held every output is forced low, pass-through included.
        if (!rst) begin
            csr_we_o     = 1'b0;
            csr_waddr_o  = '0;
            csr_wdata_o  = '0;
            hold_flag_o  = 1'b0;
            int_assert_o = INT_DEASSERT;
            int_addr_o   = '0;
        end
    end

endmodule
